// File: rtl/mux_pkg.sv
// Shared types and helpers for the registered M:1 channel selector.
// Mode encoding and round-robin pointer advance.
package mux_pkg;

    typedef enum logic {
        MODE_SELECT = 1'b0,
        MODE_RR     = 1'b1
    } mux_mode_t;

    function automatic int rr_next(input int ptr, input int m);
        return (ptr + 1 >= m) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating priority encoder: first set request at or after ptr.
// Purely combinational; scan wraps modulo M.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int M  = 4,
    localparam int SW = $clog2(M)
) (
    input  logic [M-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          found,
    output logic [SW-1:0] idx
);

    logic [M-1:0] rot;
    int           off;
    int           sum;

    always_comb begin
        rot   = M'({req, req} >> ptr);
        found = 1'b0;
        off   = 0;
        // Scan downward so the lowest rotated offset wins.
        for (int k = M - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = k;
            end
        end
        sum = int'(ptr) + off;
        if (sum >= M) begin
            sum = sum - M;
        end
        idx = SW'(sum);
    end

endmodule

// File: rtl/mux_rr_arb.sv
// Registered M:1 channel selector, SELECT or ROUND_ROBIN mode,
// valid/ready on both sides, one-entry output register.
module mux_rr_arb
    import mux_pkg::*;
#(
    parameter  int N  = 32,
    parameter  int M  = 4,
    localparam int SW = $clog2(M)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic           mode,
    input  logic [SW-1:0]  S,
    input  logic [M*N-1:0] in_data,
    input  logic [M-1:0]   in_valid,
    output logic [M-1:0]   in_ready,
    output logic [N-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [SW-1:0]  grant
);

    mux_mode_t     md;
    logic [SW-1:0] ptr;
    logic [SW-1:0] c;
    logic          c_ok;
    logic          can_load;
    logic          xfer;
    logic          arb_found;
    logic [SW-1:0] arb_idx;
    logic [N-1:0]  c_data;

    assign md = mux_mode_t'(mode);

    rr_arbiter #(
        .M(M)
    ) u_arb (
        .req  (in_valid),
        .ptr  (ptr),
        .found(arb_found),
        .idx  (arb_idx)
    );

    always_comb begin
        c    = S;
        c_ok = int'(S) < M;
        if (md == MODE_RR) begin
            c    = arb_idx;
            c_ok = arb_found;
        end
    end

    // Gating with rst keeps every in_ready low while reset is held.
    assign can_load = rst && enable && (!out_valid || out_ready);

    always_comb begin
        in_ready = '0;
        c_data   = '0;
        for (int i = 0; i < M; i++) begin
            if (c == SW'(i)) begin
                in_ready[i] = can_load && c_ok;
                c_data      = in_data[i*N +: N];
            end
        end
    end

    assign xfer = |(in_valid & in_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            grant     <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= c_data;
            grant     <= c;
            if (md == MODE_RR) begin
                ptr <= SW'(rr_next(int'(c), M));
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end
    end

endmodule

// File: tb/tb_mux_rr_arb.sv
// Scoreboard bench for mux_rr_arb: stimulus pushes expected beats,
// a negedge monitor pops and compares on each output handshake.
module tb_mux_rr_arb;

    localparam int N = 32;
    localparam int M = 4;

    typedef struct packed {
        logic [1:0]  g;
        logic [31:0] d;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic           mode;
    logic [1:0]     S;
    logic [M*N-1:0] in_data;
    logic [M-1:0]   in_valid;
    logic [M-1:0]   in_ready;
    logic [N-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [1:0]     grant;

    logic [31:0] din [4];
    beat_t       q[$];
    beat_t       mexp;
    int          passed = 0;
    int          total  = 0;
    int          rr_seq [6];

    mux_rr_arb #(
        .N(N),
        .M(M)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .mode     (mode),
        .S        (S),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .grant    (grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch);
        beat_t b;
        b.g = 2'(ch);
        b.d = din[ch];
        q.push_back(b);
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                total++;
                $display("FAIL unexpected_beat: got %h/%0d expected none",
                         out_data, grant);
            end else begin
                mexp = q.pop_front();
                chk("beat_data", out_data, mexp.d);
                chk("beat_grant", 32'(grant), 32'(mexp.g));
            end
        end else if (!out_valid) begin
            chk("idle_data_zero", out_data, 32'h0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        din[0] = 32'hE59F1020;
        din[1] = 32'h28A44EAF;
        din[2] = 32'h122225A8;
        din[3] = 32'h500A9D49;
        rr_seq = '{0, 1, 3, 0, 1, 3};

        // Reset held with enable and all channels valid
        rst       = 1'b0;
        enable    = 1'b1;
        mode      = 1'b0;
        S         = 2'd0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        in_data   = {din[3], din[2], din[1], din[0]};
        repeat (2) step;
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);

        enable = 1'b0;
        rst    = 1'b1;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'h0);
        step;
        chk("idle_in_ready2", 32'(in_ready), 32'h0);
        chk("idle_valid", 32'(out_valid), 32'h0);

        // SELECT sweep
        enable = 1'b1;
        for (int s = 0; s < 4; s++) begin
            S = 2'(s);
            push(s);
            #1;
            chk("sel_in_ready", 32'(in_ready), 32'(1 << s));
            step;
            chk("sel_grant", 32'(grant), 32'(s));
        end
        S        = 2'd2;
        in_valid = 4'b1011;
        #1;
        chk("sel_rdy_invalid", 32'(in_ready), 32'h4);
        step;
        chk("sel_drop_valid", 32'(out_valid), 32'h0);
        chk("sel_drop_data", out_data, 32'h0);

        // Round-robin fairness over channels 0,1,3
        mode = 1'b1;
        for (int k = 0; k < 6; k++) begin
            push(rr_seq[k]);
            #1;
            chk("rr_in_ready", 32'(in_ready), 32'(1 << rr_seq[k]));
            step;
            chk("rr_grant", 32'(grant), 32'(rr_seq[k]));
        end
        in_valid = 4'b0000;
        #1;
        chk("rr_none_ready", 32'(in_ready), 32'h0);
        step;
        chk("rr_none_valid", 32'(out_valid), 32'h0);

        // Backpressure after a channel-1 load
        in_valid = 4'b0010;
        push(1);
        step;
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            step;
            chk("bp_data", out_data, din[1]);
            chk("bp_grant", 32'(grant), 32'h1);
            chk("bp_valid", 32'(out_valid), 32'h1);
        end
        out_ready = 1'b1;
        push(2);
        #1;
        chk("bp_release_rdy", 32'(in_ready), 32'h4);
        step;
        chk("b2b_valid", 32'(out_valid), 32'h1);
        chk("b2b_data", out_data, din[2]);
        chk("b2b_grant", 32'(grant), 32'h2);

        // Enable drop with a beat pending
        out_ready = 1'b0;
        enable    = 1'b0;
        step;
        chk("en_hold_data", out_data, din[2]);
        chk("en_hold_rdy", 32'(in_ready), 32'h0);
        out_ready = 1'b1;
        #1;
        chk("en_drain_rdy", 32'(in_ready), 32'h0);
        step;
        chk("en_drained_valid", 32'(out_valid), 32'h0);
        chk("en_drained_data", out_data, 32'h0);
        step;
        chk("en_noload_valid", 32'(out_valid), 32'h0);
        chk("en_noload_rdy", 32'(in_ready), 32'h0);

        // Async reset during RR traffic (pointer is at 3 here)
        enable   = 1'b1;
        in_valid = 4'b1111;
        push(3);
        step;
        push(0);
        step;
        #5;
        rst = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid), 32'h0);
        chk("ar_data", out_data, 32'h0);
        chk("ar_in_ready", 32'(in_ready), 32'h0);
        step;
        rst = 1'b1;
        push(0);
        #1;
        chk("ar_restart_rdy", 32'(in_ready), 32'h1);
        step;
        chk("ar_restart_grant", 32'(grant), 32'h0);
        push(1);
        step;
        chk("ar_next_grant", 32'(grant), 32'h1);
        in_valid = 4'b0000;
        repeat (2) step;

        chk("queue_empty", 32'(q.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mux_rr_arb.md
Name: mux_rr_arb

Overview:
- Registered M-to-1 channel selector with valid/ready handshakes; successor to the combinational 4:1 N-bit mux with enable.
- Two modes: SELECT (channel chosen by S, legacy behaviour) and ROUND_ROBIN (fair arbitration among valid channels).
- Single-entry output register gives 1-cycle latency and full throughput.
- Sits between multiple producers (e.g. writeback/forwarding sources, memory requesters) and one consumer in the processor datapath.

Parameters:
- N, 32, data width in bits.
- M, 4, number of input channels (≥2).
- SW, $clog2(M), select/grant index width (derived; not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  1 = accept new beats; 0 = block inputs, pending output beat still drains.
- mode  input  1  0 = SELECT, 1 = ROUND_ROBIN.
- S  input  SW  channel index, used in SELECT mode only.
- in_data  input  M*N  flattened channel data; channel i occupies bits [i*N +: N].
- in_valid  input  M  per-channel valid.
- in_ready  output  M  per-channel ready, one-hot or zero.
- out_data  output  N  registered data; forced to 0 whenever out_valid=0.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.
- grant  output  SW  index of the channel whose beat is held in the output register.

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0, out_data=0, grant=0, RR pointer ptr=0; all in_ready=0 while reset is asserted.
- can_load = enable && (!out_valid || out_ready).
- Chosen channel c:
  - SELECT: c = S.
  - ROUND_ROBIN: c = first i with in_valid[i]=1, scanning ptr, ptr+1, …, M-1, 0, …, ptr-1 (modulo M).
  - No valid channel in ROUND_ROBIN: no load; in_ready stays 0.
- in_ready[i] = can_load && (i == c), combinational, no registered stall state.
  - SELECT: in_ready[S] is asserted even when in_valid[S]=0.
  - ROUND_ROBIN: in_ready is asserted only toward a valid channel.
- Transfer on channel i occurs when in_valid[i] && in_ready[i] at a clock edge:
  - out_data ← channel i data, out_valid ← 1, grant ← i.
  - ROUND_ROBIN only: ptr ← (i+1) mod M. ptr is unchanged in SELECT mode.
- Output drain: out_valid && out_ready with no simultaneous transfer → out_valid ← 0, out_data ← 0, grant holds its value.
- Simultaneous drain and load in the same cycle: the new beat replaces the old one; out_valid stays 1, giving back-to-back throughput of 1 beat/cycle.
- Stall: out_valid && !out_ready → all in_ready=0; out_data and grant held stable.
- enable falling while a beat is pending: the beat is kept and drains normally; no new loads.
- mode or S changing mid-stream: takes effect at the next transfer decision; the held beat is unaffected and ptr is not reset.
- S ≥ M (non-power-of-two M): no channel is selected; no load.
- Latency: input beat appears at the output 1 cycle after its transfer edge.
- No combinational path from in_data to out_data.

Decomposition:
- Package mux_pkg:
  - typedef enum logic {MODE_SELECT=0, MODE_RR=1} mux_mode_t.
  - Helper function rr_next(ptr, M) returning (ptr+1) mod M.
- Sub-module rr_arbiter #(M):
  - Inputs: req[M], ptr.
  - Outputs: found, idx[SW].
  - Purely combinational rotating priority encoder.
- mux_rr_arb owns: the output register, ptr, and mode/S muxing of the chosen index.

Test Plan:
1. Reset/idle:
   - Stimulus: rst=0 with in_valid=4'b1111, then release rst.
   - Required: out_valid=0, out_data=0, grant=0, in_ready=0 throughout reset; after release with enable=0, in_ready stays 0.
2. SELECT, enable=1, out_ready=1, all valid, data I0=32'hE59F1020, I1=32'h28A44EAF, I2=32'h122225A8, I3=32'h500A9D49, S stepped 0→1→2→3:
   - Required: each value appears at out_data one cycle after its S step, with grant=S.
   - Then S=2 with in_valid[2]=0: out_valid falls to 0 and out_data=0.
3. ROUND_ROBIN fairness:
   - Stimulus: in_valid=4'b1011 held constant, out_ready=1.
   - Required: grant sequence 0,1,3,0,1,3…; channel 2 is never granted; one beat per cycle.
4. Backpressure:
   - Stimulus: out_ready=0 for 3 cycles after a load from channel 1.
   - Required: out_data and grant stay at channel 1 values; in_ready=0 for all 3 cycles.
   - Then out_ready=1: the drain and the next load occur in the same cycle.
5. Enable drop:
   - Stimulus: enable→0 while out_valid=1 and out_ready=0, then out_ready=1.
   - Required: the held beat drains, then out_valid=0, out_data=0, and no new load while enable=0.
6. Async reset mid-stream:
   - Stimulus: assert rst between clock edges during RR traffic.
   - Required: out_valid=0 and out_data=0 immediately, without waiting for a clock edge.
   - After release: arbitration restarts from channel 0 (ptr=0).
